// File: rtl/esdi_pkg.sv
`default_nettype none
// ============================================================================
// Module  : esdi_pkg
// Purpose : Shared types and constants for the ESDI sector write-back path.
//           Holds the scheduler FSM state enum, the done-record error codes
//           and the packed done-record layout {sector, err}.
// Ports   : none (package)
// Revision: 1.0  initial release
// ============================================================================
package esdi_pkg;

  typedef enum logic [2:0] {
    WB_IDLE     = 3'd0,
    WB_CMD      = 3'd1,
    WB_STREAM   = 3'd2,
    WB_DRAIN    = 3'd3,
    WB_WAIT_STS = 3'd4,
    WB_PUSH     = 3'd5
  } wb_state_t;

  localparam logic [1:0] WB_ERR_NONE  = 2'b00;
  localparam logic [1:0] WB_ERR_SHORT = 2'b01;
  localparam logic [1:0] WB_ERR_LONG  = 2'b10;
  localparam logic [1:0] WB_ERR_DMA   = 2'b11;

  typedef struct packed {
    logic [7:0] sector;
    logic [1:0] err;
  } wb_done_t;

endpackage
`default_nettype wire

// File: rtl/wb_done_fifo.sv
`default_nettype none
// ============================================================================
// Module  : wb_done_fifo
// Purpose : Synchronous ready/valid FIFO for done records. A write is accepted
//           while full if a read happens in the same cycle, so a full queue
//           stays full under simultaneous push/pop.
// Ports   : clk, rst_n (async active-low)
//           in_valid/in_ready/in_data    write side
//           out_valid/out_ready/out_data read side (show-ahead)
//           full, empty                  occupancy flags
// Revision: 1.0  initial release
// ============================================================================
module wb_done_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  // One extra pointer bit distinguishes full from empty.
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             wr_en;
  logic             rd_en;

  assign empty     = (wr_ptr_q == rd_ptr_q);
  assign full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign out_valid = !empty;
  assign in_ready  = !full || out_ready;
  assign out_data  = mem_q[rd_ptr_q[AW-1:0]];
  assign wr_en     = in_valid && in_ready;
  assign rd_en     = out_valid && out_ready;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_en) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
    if (rd_en) rd_ptr_d = rd_ptr_q + (AW+1)'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= in_data;
  end

endmodule
`default_nettype wire

// File: rtl/sector_writeback_sched.sv
`default_nettype none
// ============================================================================
// Module  : sector_writeback_sched
// Purpose : Sequences write-back of captured sectors to memory. For each
//           sector seen on the input stream it issues one DMA command at
//           base_addr + (tid << sector_shift), forwards exactly sector_len
//           bytes (flagging short/long sectors), waits for DMA status and
//           queues a {sector, err} done record.
// Options : SECTOR_WB_TIMEOUT_EN - status watchdog; after TIMEOUT cycles in
//           WAIT_STS the sector is closed with err=2'b11.
// Ports   : aclk, aresetn (async active-low)
//           enable, base_addr, sector_shift, sector_len  configuration
//           s_t*    byte stream in (tid = sector number)
//           m_t*    byte stream out to DMA (combinational pass-through)
//           cmd_*   DMA command (addr, len)
//           sts_*   DMA completion strobe / result
//           done_*  done-record queue
//           busy, err_count  status
// Revision: 1.0  initial release
// ============================================================================
module sector_writeback_sched
  import esdi_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int LEN_W      = 11,
  parameter int DONE_DEPTH = 4,
  parameter int TIMEOUT    = 4096
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic              enable,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [4:0]        sector_shift,
  input  logic [LEN_W-1:0]  sector_len,
  input  logic              s_tvalid,
  output logic              s_tready,
  input  logic [7:0]        s_tdata,
  input  logic              s_tlast,
  input  logic [7:0]        s_tid,
  output logic              m_tvalid,
  input  logic              m_tready,
  output logic [7:0]        m_tdata,
  output logic              m_tlast,
  output logic              cmd_valid,
  input  logic              cmd_ready,
  output logic [ADDR_W-1:0] cmd_addr,
  output logic [LEN_W-1:0]  cmd_len,
  input  logic              sts_valid,
  input  logic              sts_okay,
  output logic              done_valid,
  input  logic              done_ready,
  output logic [7:0]        done_sector,
  output logic [1:0]        done_err,
  output logic              busy,
  output logic [7:0]        err_count
);

  wb_state_t         state_q, state_d;
  logic [7:0]        tid_q, tid_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic [1:0]        err_q, err_d;
  logic [7:0]        err_count_q, err_count_d;

  logic [ADDR_W-1:0] tid_ext;
  logic              cnt_last;
  logic              wd_expired;
  logic              fifo_in_valid;
  logic              fifo_in_ready;
  logic              fifo_full;
  logic              fifo_empty;
  logic              unused_flags;
  wb_done_t          push_rec;
  wb_done_t          pop_rec;

  assign tid_ext  = ADDR_W'(s_tid);
  assign cnt_last = (cnt_q == (len_q - LEN_W'(1)));

`ifdef SECTOR_WB_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT + 1);
  logic [WD_W-1:0] wd_q, wd_d;

  // Counts only while waiting for status; cleared in every other state.
  always_comb begin
    wd_d = '0;
    if (state_q == WB_WAIT_STS) wd_d = wd_q + WD_W'(1);
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) wd_q <= '0;
    else          wd_q <= wd_d;
  end

  assign wd_expired = (state_q == WB_WAIT_STS) && (wd_q == WD_W'(TIMEOUT - 1));
`else
  logic [31:0] unused_timeout;
  assign unused_timeout = TIMEOUT;
  assign wd_expired     = 1'b0;
`endif

  always_comb begin
    state_d       = state_q;
    tid_d         = tid_q;
    addr_d        = addr_q;
    len_d         = len_q;
    cnt_d         = cnt_q;
    err_d         = err_q;
    err_count_d   = err_count_q;
    s_tready      = 1'b0;
    m_tvalid      = 1'b0;
    m_tdata       = s_tdata;
    m_tlast       = 1'b0;
    cmd_valid     = 1'b0;
    fifo_in_valid = 1'b0;

    case (state_q)
      WB_IDLE: begin
        // Configuration is captured here so it stays stable for the sector.
        if (s_tvalid && enable) begin
          tid_d   = s_tid;
          addr_d  = base_addr + (tid_ext << sector_shift);
          len_d   = sector_len;
          err_d   = WB_ERR_NONE;
          state_d = WB_CMD;
        end
      end

      WB_CMD: begin
        cmd_valid = 1'b1;
        cnt_d     = '0;
        if (cmd_ready) state_d = WB_STREAM;
      end

      WB_STREAM: begin
        m_tvalid = s_tvalid;
        s_tready = m_tready;
        // An early input last still terminates the DMA packet on that beat.
        m_tlast  = cnt_last || s_tlast;
        if (s_tvalid && m_tready) begin
          cnt_d = cnt_q + LEN_W'(1);
          if (s_tlast && !cnt_last) begin
            err_d   = err_q | WB_ERR_SHORT;
            state_d = WB_WAIT_STS;
          end else if (cnt_last && !s_tlast) begin
            err_d   = err_q | WB_ERR_LONG;
            state_d = WB_DRAIN;
          end else if (cnt_last) begin
            state_d = WB_WAIT_STS;
          end
        end
      end

      WB_DRAIN: begin
        // Surplus bytes are swallowed up to and including the input last.
        s_tready = 1'b1;
        if (s_tvalid && s_tlast) state_d = WB_WAIT_STS;
      end

      WB_WAIT_STS: begin
        if (sts_valid) begin
          if (!sts_okay) err_d = WB_ERR_DMA;
          state_d = WB_PUSH;
        end else if (wd_expired) begin
          err_d   = WB_ERR_DMA;
          state_d = WB_PUSH;
        end
      end

      WB_PUSH: begin
        fifo_in_valid = 1'b1;
        if (fifo_in_ready) begin
          state_d = WB_IDLE;
          if ((err_q != WB_ERR_NONE) && (err_count_q != 8'hff))
            err_count_d = err_count_q + 8'd1;
        end
      end

      default: state_d = WB_IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q     <= WB_IDLE;
      tid_q       <= '0;
      addr_q      <= '0;
      len_q       <= '0;
      cnt_q       <= '0;
      err_q       <= WB_ERR_NONE;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      tid_q       <= tid_d;
      addr_q      <= addr_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
      err_count_q <= err_count_d;
    end
  end

  assign push_rec = '{sector: tid_q, err: err_q};

  wb_done_fifo #(
    .WIDTH ($bits(wb_done_t)),
    .DEPTH (DONE_DEPTH)
  ) u_done_fifo (
    .clk       (aclk),
    .rst_n     (aresetn),
    .in_valid  (fifo_in_valid),
    .in_ready  (fifo_in_ready),
    .in_data   (push_rec),
    .out_valid (done_valid),
    .out_ready (done_ready),
    .out_data  (pop_rec),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign unused_flags = fifo_full ^ fifo_empty;

  assign cmd_addr    = addr_q;
  assign cmd_len     = len_q;
  assign done_sector = pop_rec.sector;
  assign done_err    = pop_rec.err;
  assign busy        = (state_q != WB_IDLE);
  assign err_count   = err_count_q;

endmodule
`default_nettype wire

// File: tb/tb_sector_writeback_sched.sv
`default_nettype none
// ============================================================================
// Module  : tb_sector_writeback_sched
// Purpose : Directed self-checking bench for sector_writeback_sched.
//           Inputs change 1 time unit after the rising edge; outputs and
//           handshakes are observed on the falling edge.
// Revision: 1.0  initial release
// ============================================================================
module tb_sector_writeback_sched;

  logic        aclk;
  logic        aresetn;
  logic        enable;
  logic [31:0] base_addr;
  logic [4:0]  sector_shift;
  logic [10:0] sector_len;
  logic        s_tvalid, s_tready, s_tlast;
  logic [7:0]  s_tdata, s_tid;
  logic        m_tvalid, m_tready, m_tlast;
  logic [7:0]  m_tdata;
  logic        cmd_valid, cmd_ready;
  logic [31:0] cmd_addr;
  logic [10:0] cmd_len;
  logic        sts_valid, sts_okay;
  logic        done_valid, done_ready;
  logic [7:0]  done_sector;
  logic [1:0]  done_err;
  logic        busy;
  logic [7:0]  err_count;

  int n_tests = 0;
  int n_fail  = 0;

  // stream / command monitor state
  int          mbeats;
  int          mlast_idx;
  int          drain_cnt;
  int          data_err;
  logic [7:0]  cur_tid;
  logic [31:0] cmd_addr_seen;
  logic [10:0] cmd_len_seen;
  int          cmd_unstable;
  logic        cmd_hold;
  logic [31:0] hold_addr;

  // ready drivers
  bit          tog_mode;
  int          cmd_delay;
  int          cwait;

  logic [7:0]  pop_sec;
  logic [1:0]  pop_err;

  sector_writeback_sched #(
    .ADDR_W     (32),
    .LEN_W      (11),
    .DONE_DEPTH (4),
    .TIMEOUT    (16)
  ) dut (
    .aclk         (aclk),
    .aresetn      (aresetn),
    .enable       (enable),
    .base_addr    (base_addr),
    .sector_shift (sector_shift),
    .sector_len   (sector_len),
    .s_tvalid     (s_tvalid),
    .s_tready     (s_tready),
    .s_tdata      (s_tdata),
    .s_tlast      (s_tlast),
    .s_tid        (s_tid),
    .m_tvalid     (m_tvalid),
    .m_tready     (m_tready),
    .m_tdata      (m_tdata),
    .m_tlast      (m_tlast),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_addr     (cmd_addr),
    .cmd_len      (cmd_len),
    .sts_valid    (sts_valid),
    .sts_okay     (sts_okay),
    .done_valid   (done_valid),
    .done_ready   (done_ready),
    .done_sector  (done_sector),
    .done_err     (done_err),
    .busy         (busy),
    .err_count    (err_count)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  // m_tready / cmd_ready drivers, updated just after each rising edge.
  initial begin
    m_tready  = 1'b1;
    cmd_ready = 1'b1;
    cwait     = 0;
    forever begin
      @(posedge aclk);
      #1;
      m_tready = tog_mode ? ~m_tready : 1'b1;
      if (!cmd_valid) begin
        cwait     = 0;
        cmd_ready = (cmd_delay == 0);
      end else begin
        cwait++;
        cmd_ready = (cwait >= cmd_delay);
      end
    end
  end

  // Output-side monitor: expected byte i of a sector is (i + tid).
  initial begin
    cmd_hold  = 1'b0;
    hold_addr = '0;
    forever begin
      @(negedge aclk);
      if (m_tvalid && m_tready) begin
        if (m_tdata !== (8'(mbeats) + cur_tid)) data_err++;
        if (m_tlast && (mlast_idx < 0)) mlast_idx = mbeats;
        mbeats++;
      end
      if (s_tvalid && s_tready && !m_tvalid) drain_cnt++;
      if (cmd_valid && cmd_ready) begin
        cmd_addr_seen = cmd_addr;
        cmd_len_seen  = cmd_len;
      end
      if (cmd_valid && cmd_hold && (cmd_addr !== hold_addr)) cmd_unstable++;
      cmd_hold  = cmd_valid && !cmd_ready;
      hold_addr = cmd_addr;
    end
  end

  task automatic send_sector(input logic [7:0] id, input int nbytes, input bit chk_lat);
    bit acc;
    int k;
    cur_tid   = id;
    mbeats    = 0;
    mlast_idx = -1;
    drain_cnt = 0;
    data_err  = 0;
    for (int i = 0; i < nbytes; i++) begin
      s_tvalid = 1'b1;
      s_tdata  = 8'(i) + id;
      s_tlast  = (i == nbytes - 1);
      s_tid    = id;
      acc      = 1'b0;
      k        = 0;
      while (!acc) begin
        @(negedge aclk);
        if (chk_lat && (i == 0) && (k == 0)) check_eq("cmd_valid_lat0", cmd_valid, 0);
        if (chk_lat && (i == 0) && (k == 1)) check_eq("cmd_valid_lat1", cmd_valid, 1);
        if (s_tready) acc = 1'b1;
        k++;
        step();
        if (!acc && (k > 2000)) begin
          check_eq("beat_timeout", 1, 0);
          s_tvalid = 1'b0;
          s_tlast  = 1'b0;
          return;
        end
      end
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  // Issues a status pulse two cycles into WAIT_STS.
  task automatic send_sts(input bit ok);
    step();
    step();
    sts_valid = 1'b1;
    sts_okay  = ok;
    step();
    sts_valid = 1'b0;
    sts_okay  = 1'b1;
  endtask

  task automatic pop_done(output logic [7:0] sec, output logic [1:0] err);
    bit got;
    got  = 1'b0;
    sec  = 8'hxx;
    err  = 2'bxx;
    done_ready = 1'b1;
    for (int k = 0; k < 500 && !got; k++) begin
      @(negedge aclk);
      if (done_valid) begin
        got = 1'b1;
        sec = done_sector;
        err = done_err;
      end
      step();
    end
    done_ready = 1'b0;
    if (!got) check_eq("done_timeout", 0, 1);
  endtask

  initial begin
    aresetn      = 1'b0;
    enable       = 1'b1;
    base_addr    = 32'h1000_0000;
    sector_shift = 5'd10;
    sector_len   = 11'd1024;
    s_tvalid     = 1'b0;
    s_tdata      = '0;
    s_tlast      = 1'b0;
    s_tid        = '0;
    sts_valid    = 1'b0;
    sts_okay     = 1'b1;
    done_ready   = 1'b0;
    tog_mode     = 1'b0;
    cmd_delay    = 0;
    cmd_unstable = 0;
    mbeats       = 0;
    mlast_idx    = -1;
    drain_cnt    = 0;
    data_err     = 0;
    cur_tid      = '0;
    cmd_addr_seen = '0;
    cmd_len_seen  = '0;

    // ---- reset state
    repeat (3) step();
    @(negedge aclk);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_cmd_valid", cmd_valid, 0);
    check_eq("rst_m_tvalid", m_tvalid, 0);
    check_eq("rst_s_tready", s_tready, 0);
    check_eq("rst_done_valid", done_valid, 0);
    check_eq("rst_err_count", err_count, 0);
    step();
    aresetn = 1'b1;
    step();

    // ---- enable low blocks a new sector
    enable   = 1'b0;
    s_tvalid = 1'b1;
    s_tid    = 8'h01;
    repeat (4) step();
    @(negedge aclk);
    check_eq("en_gate_busy", busy, 0);
    check_eq("en_gate_s_tready", s_tready, 0);
    step();
    s_tvalid = 1'b0;
    enable   = 1'b1;
    step();

    // ---- T1: nominal 1024-byte sector
    send_sector(8'h05, 1024, 1'b1);
    check_eq("t1_cmd_addr", cmd_addr_seen, 32'h1000_1400);
    check_eq("t1_cmd_len", 32'(cmd_len_seen), 1024);
    check_eq("t1_beats", mbeats, 1024);
    check_eq("t1_mlast_idx", mlast_idx, 1023);
    check_eq("t1_data", data_err, 0);
    send_sts(1'b1);
    @(negedge aclk);
    check_eq("t1_push_busy", busy, 1);
    check_eq("t1_done_lat0", done_valid, 0);
    step();
    @(negedge aclk);
    check_eq("t1_done_lat1", done_valid, 1);
    check_eq("t1_idle_busy", busy, 0);
    step();
    pop_done(pop_sec, pop_err);
    check_eq("t1_done_sector", pop_sec, 8'h05);
    check_eq("t1_done_err", pop_err, 2'b00);
    check_eq("t1_err_count", err_count, 0);

    // ---- T2: short sector, 1000 of 1024 bytes
    send_sector(8'h22, 1000, 1'b0);
    check_eq("t2_cmd_addr", cmd_addr_seen, 32'h1000_8800);
    check_eq("t2_beats", mbeats, 1000);
    check_eq("t2_mlast_idx", mlast_idx, 999);
    check_eq("t2_data", data_err, 0);
    send_sts(1'b1);
    pop_done(pop_sec, pop_err);
    check_eq("t2_done_sector", pop_sec, 8'h22);
    check_eq("t2_done_err", pop_err, 2'b01);
    check_eq("t2_err_count", err_count, 1);

    // ---- T3: long sector, 1030 bytes against 1024
    send_sector(8'h33, 1030, 1'b0);
    check_eq("t3_cmd_addr", cmd_addr_seen, 32'h1000_CC00);
    check_eq("t3_beats", mbeats, 1024);
    check_eq("t3_mlast_idx", mlast_idx, 1023);
    check_eq("t3_drain", drain_cnt, 6);
    check_eq("t3_data", data_err, 0);
    send_sts(1'b1);
    pop_done(pop_sec, pop_err);
    check_eq("t3_done_err", pop_err, 2'b10);
    check_eq("t3_err_count", err_count, 2);

    // ---- T3b: DMA reports failure
    sector_len = 11'd4;
    send_sector(8'h08, 4, 1'b0);
    check_eq("t3b_cmd_len", 32'(cmd_len_seen), 4);
    send_sts(1'b0);
    pop_done(pop_sec, pop_err);
    check_eq("t3b_done_sector", pop_sec, 8'h08);
    check_eq("t3b_done_err", pop_err, 2'b11);
    check_eq("t3b_err_count", err_count, 3);

    // ---- T4: done queue backpressure, 5 sectors into depth 4
    base_addr    = 32'h0000_2000;
    sector_shift = 5'd4;
    for (int i = 0; i < 5; i++) begin
      send_sector(8'h40 + 8'(i), 4, 1'b0);
      send_sts(1'b1);
    end
    check_eq("t4_cmd_addr", cmd_addr_seen, 32'h0000_2440);
    repeat (6) step();
    @(negedge aclk);
    check_eq("t4_push_stall", busy, 1);
    check_eq("t4_done_valid", done_valid, 1);
    step();
    pop_done(pop_sec, pop_err);
    check_eq("t4_pop0", pop_sec, 8'h40);
    @(negedge aclk);
    check_eq("t4_unstall", busy, 0);
    step();
    for (int i = 1; i < 5; i++) begin
      pop_done(pop_sec, pop_err);
      check_eq("t4_pop_order", pop_sec, 8'h40 + 8'(i));
      check_eq("t4_pop_err", pop_err, 2'b00);
    end
    @(negedge aclk);
    check_eq("t4_empty", done_valid, 0);
    step();

    // ---- T5: stray status, slow cmd_ready, toggling m_tready
    sts_valid = 1'b1;
    sts_okay  = 1'b0;
    step();
    sts_valid = 1'b0;
    sts_okay  = 1'b1;
    sector_len = 11'd16;
    tog_mode   = 1'b1;
    cmd_delay  = 7;
    cmd_unstable = 0;
    send_sector(8'h07, 16, 1'b0);
    check_eq("t5_cmd_addr", cmd_addr_seen, 32'h0000_2070);
    check_eq("t5_cmd_stable", cmd_unstable, 0);
    check_eq("t5_beats", mbeats, 16);
    check_eq("t5_mlast_idx", mlast_idx, 15);
    check_eq("t5_data", data_err, 0);
    send_sts(1'b1);
    pop_done(pop_sec, pop_err);
    check_eq("t5_done_sector", pop_sec, 8'h07);
    check_eq("t5_done_err", pop_err, 2'b00);
    check_eq("t5_err_count", err_count, 3);
    tog_mode  = 1'b0;
    cmd_delay = 0;
    repeat (2) step();

`ifdef SECTOR_WB_TIMEOUT_EN
    // ---- status watchdog: no sts_valid, closes after 16 WAIT_STS cycles
    sector_len = 11'd4;
    send_sector(8'h0A, 4, 1'b0);
    repeat (17) @(negedge aclk);
    check_eq("wd_done_lat0", done_valid, 0);
    @(negedge aclk);
    check_eq("wd_done_lat1", done_valid, 1);
    step();
    pop_done(pop_sec, pop_err);
    check_eq("wd_done_sector", pop_sec, 8'h0A);
    check_eq("wd_done_err", pop_err, 2'b11);
    check_eq("wd_err_count", err_count, 4);
`endif

    // ---- reset asserted mid-STREAM
    sector_len = 11'd16;
    s_tvalid   = 1'b1;
    s_tdata    = 8'h5A;
    s_tlast    = 1'b0;
    s_tid      = 8'h09;
    repeat (5) step();
    @(negedge aclk);
    check_eq("mid_busy", busy, 1);
    check_eq("mid_m_tvalid", m_tvalid, 1);
    step();
    aresetn = 1'b0;
    @(negedge aclk);
    check_eq("mrst_busy", busy, 0);
    check_eq("mrst_s_tready", s_tready, 0);
    check_eq("mrst_m_tvalid", m_tvalid, 0);
    check_eq("mrst_cmd_valid", cmd_valid, 0);
    check_eq("mrst_done_valid", done_valid, 0);
    check_eq("mrst_err_count", err_count, 0);
    step();
    s_tvalid = 1'b0;
    aresetn  = 1'b1;
    repeat (20) step();
    @(negedge aclk);
    check_eq("mrst_no_record", done_valid, 0);
    check_eq("mrst_idle", busy, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global guard against a stuck run.
  initial begin
    #2000000;
    $display("FAIL global_timeout: got 1 expected 0");
    $fatal(1, "simulation time limit");
  end

endmodule
`default_nettype wire

// File: doc/sector_writeback_sched.md
# sector_writeback_sched

Sequences write-back of dirty sectors captured by the ESDI write datapath into system memory. Consumes the datapath's byte stream (sector number on `tid`), issues one S2MM DMA command per sector at `base_addr + (tid << sector_shift)`, and forwards the bytes with an enforced length. Collects DMA completion status and queues per-sector done records for software.

## Interface
Parameters:
- `ADDR_W`, 32, DMA address width
- `LEN_W`, 11, byte-count width (max sector 2047 bytes)
- `DONE_DEPTH`, 4, done-queue entries (power of 2)
- `TIMEOUT`, 4096, status watchdog cycles (used only with the watchdog macro)

Ports:
- `aclk`  in  1  clock
- `aresetn`  in  1  asynchronous active-low reset
- `enable`  in  1  accept new sectors
- `base_addr`  in  ADDR_W  buffer base address
- `sector_shift`  in  5  log2 of the per-sector stride
- `sector_len`  in  LEN_W  expected bytes per sector (≥1)
- `s_tvalid`/`s_tready`/`s_tdata[7:0]`/`s_tlast`/`s_tid[7:0]`  in/out/in/in/in  stream from the datapath
- `m_tvalid`/`m_tready`/`m_tdata[7:0]`/`m_tlast`  out/in/out/out  stream to the DMA
- `cmd_valid`/`cmd_ready`/`cmd_addr[ADDR_W]`/`cmd_len[LEN_W]`  out/in/out/out  DMA command
- `sts_valid`/`sts_okay`  in/in  DMA completion strobe and result
- `done_valid`/`done_ready`/`done_sector[7:0]`/`done_err[1:0]`  out/in/out/out  done queue
- `busy`  out  1  FSM not in IDLE
- `err_count`  out  8  saturating count of errored sectors

## Operation
- FSM states are IDLE, CMD, STREAM, DRAIN, WAIT_STS and PUSH.
- IDLE: `s_tready`=0. When `s_tvalid & enable`, latch `tid`, register `cmd_addr = base_addr + ({tid} << sector_shift)` (truncated to ADDR_W), register `cmd_len = sector_len`, then go to CMD.
- CMD: hold `cmd_valid` with stable fields until `cmd_ready`, then go to STREAM. Byte counter is cleared.
- STREAM: pass-through, with `m_tvalid=s_tvalid`, `s_tready=m_tready`, `m_tdata=s_tdata`. On each transfer the counter increments. `m_tlast` = (counter==sector_len-1).
  - Early `s_tlast` before the count is reached: mark error bit0 (short), assert `m_tlast` on that beat, go to WAIT_STS.
  - Count reached without `s_tlast`: mark error bit1 (long), go to DRAIN.
  - Both reached together: normal completion, go to WAIT_STS.
- DRAIN: `s_tready`=1 and `m_tvalid`=0. Discard beats through the `s_tlast` beat, then go to WAIT_STS.
- WAIT_STS: wait for `sts_valid`. If `!sts_okay`, set both error bits. Go to PUSH.
- PUSH: write {sector, err} into the done queue when it is not full, then go to IDLE. If the queue is full, stall in PUSH. `err_count` increments (saturating at 255) when err≠0.
- `enable` deasserted mid-sector: the current sector completes normally; no new sector starts.
- `sts_valid` outside WAIT_STS is ignored.
- `sector_len`, `base_addr` and `sector_shift` are sampled only in IDLE.

## Timing
- Reset values: FSM=IDLE, `cmd_valid`=0, `m_tvalid`=0, `s_tready`=0, `done_valid`=0, `busy`=0, `err_count`=0, done queue empty.
- Reset asserted mid-sector aborts immediately with no done record.
- `cmd_valid` rises 1 cycle after `s_tvalid` is first seen in IDLE.
- The first data beat can transfer in the cycle after `cmd_ready`.
- STREAM adds zero latency and is fully combinational s→m. The data path carries no register stage.
- The done entry becomes visible (`done_valid`) 1 cycle after the PUSH write.
- Minimum sector overhead is 4 cycles (IDLE→CMD→…→WAIT_STS→PUSH) plus DMA latency.
- Done queue: simultaneous read and write when full is allowed and keeps it full. `done_valid` drops the cycle after the last pop.

## Configuration
- `SECTOR_WB_TIMEOUT_EN` defined: a watchdog counts cycles in WAIT_STS. On reaching TIMEOUT, it sets err=2'b11, goes to PUSH, and ignores the late status.
- Undefined: WAIT_STS waits indefinitely and the counter logic is absent.

## Structure
- Shared package `esdi_pkg`:
  - FSM state enum `wb_state_t`.
  - Error code constants `WB_ERR_SHORT=2'b01`, `WB_ERR_LONG=2'b10`, `WB_ERR_DMA=2'b11`.
  - Done-record struct (sector, err).
- Sub-module `wb_done_fifo`: synchronous FIFO, width 10, depth DONE_DEPTH, ready/valid on both sides, with full and empty flags.

## Test plan
- sector_len=1024, tid=0x05, base=0x1000_0000, shift=10, 1024 bytes with last on the final beat, sts_okay=1 -> cmd_addr=0x1000_1400, cmd_len=1024, m_tlast on beat 1023, done={0x05, 00}.
- 1000 bytes with early tlast, sector_len=1024 -> m_tlast on beat 999, done err=01, err_count=1.
- 1030 bytes, sector_len=1024 -> m_tlast on beat 1023, 6 beats drained with `s_tready`=1, done err=10.
- 5 sectors with `done_ready`=0 and DONE_DEPTH=4 -> 4 entries queued, FSM stalls in PUSH. The 5th record pushes only after one pop, and entries come out in order.
- `m_tready` toggled every other cycle plus cmd_ready delayed 7 cycles -> no byte lost or duplicated, and the scoreboard matches.
- With `SECTOR_WB_TIMEOUT_EN` and TIMEOUT=16, no sts_valid -> done err=11 after 16 cycles in WAIT_STS. Reset asserted mid-STREAM -> all outputs return to reset values with no done record.
